// File: rtl/gate_identifier.sv
// Sequential truth-table tester for one two-input gate: sweeps {a,b} = 00..11,
// samples the gate output after SETTLE_CYCLES idle cycles, then classifies the table.
// Ports: clk/rst (sync, active-high); start/expect_code request a sweep; dut_a/dut_b
// drive the gate and dut_y reads it back; busy/done/truth/func_code/pass report status.
module gate_identifier #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] expect_code,
    output logic       busy,
    output logic       done,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic [3:0] truth,
    output logic [2:0] func_code,
    output logic       pass
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;

    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

    localparam logic [2:0] FN_UNKNOWN = 3'd0;
    localparam logic [2:0] FN_AND     = 3'd1;
    localparam logic [2:0] FN_OR      = 3'd2;
    localparam logic [2:0] FN_XOR     = 3'd3;
    localparam logic [2:0] FN_NOR     = 3'd4;
    localparam logic [2:0] FN_NAND    = 3'd5;
    localparam logic [2:0] FN_XNOR    = 3'd6;
    localparam logic [2:0] FN_NOT_A   = 3'd7;

    logic [1:0] state;
    logic [1:0] vec;
    logic [1:0] vec_next;
    logic [7:0] cnt;
    logic [2:0] exp_q;
    // Samples for vectors 0..2 shift in from the top, so after three samples
    // shadow = {y(10), y(01), y(00)} and the fourth sample completes the table.
    logic [2:0] shadow;
    logic [3:0] table_new;
    logic [2:0] code_new;

    function automatic logic [2:0] classify(input logic [3:0] t);
        case (t)
            4'b1000: classify = FN_AND;
            4'b1110: classify = FN_OR;
            4'b0110: classify = FN_XOR;
            4'b0001: classify = FN_NOR;
            4'b0111: classify = FN_NAND;
            4'b1001: classify = FN_XNOR;
            4'b0011: classify = FN_NOT_A;
            default: classify = FN_UNKNOWN;
        endcase
    endfunction

    assign vec_next  = vec + 2'd1;
    assign table_new = {dut_y, shadow};
    assign code_new  = classify(table_new);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            vec       <= 2'd0;
            cnt       <= 8'd0;
            exp_q     <= 3'd0;
            shadow    <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dut_a     <= 1'b0;
            dut_b     <= 1'b0;
            truth     <= 4'd0;
            func_code <= 3'd0;
            pass      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        vec    <= 2'd0;
                        dut_a  <= 1'b0;
                        dut_b  <= 1'b0;
                        cnt    <= SETTLE_INIT;
                        exp_q  <= expect_code;
                        shadow <= 3'd0;
                        busy   <= 1'b1;
                        state  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == 8'd0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (vec != 2'd3) begin
                        shadow         <= {dut_y, shadow[2:1]};
                        vec            <= vec_next;
                        {dut_a, dut_b} <= vec_next;
                        cnt            <= SETTLE_INIT;
                        state          <= ST_SETTLE;
                    end else begin
                        // Commit uses the bit sampled this cycle, not a stale shadow.
                        truth     <= table_new;
                        func_code <= code_new;
                        pass      <= (code_new == exp_q);
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_identifier.sv
module tb_gate_identifier;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start_v = 3'b000;
    logic [2:0] exp_v [3];
    logic [2:0] busy_v, done_v, a_v, b_v, y_v;
    logic [3:0] truth_v [3];
    logic [2:0] func_v [3];
    logic [2:0] pass_v;

    // Gate models: arbitrary truth table per instance, optional 2-cycle latency.
    logic [3:0] tbl_v [3];
    logic [2:0] lat_v = 3'b000;
    logic [2:0] p1 = 3'b000, p2 = 3'b000;
    int         dcount [3] = '{0, 0, 0};

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [3:0] KNOWN [8] = '{4'b0000, 4'b1000, 4'b1110, 4'b0110,
                                         4'b0001, 4'b0111, 4'b1001, 4'b0011};

    always #5 clk = ~clk;

    gate_identifier #(.SETTLE_CYCLES(1)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .expect_code(exp_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .dut_a(a_v[0]), .dut_b(b_v[0]),
        .dut_y(y_v[0]), .truth(truth_v[0]), .func_code(func_v[0]), .pass(pass_v[0]));

    gate_identifier #(.SETTLE_CYCLES(2)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .expect_code(exp_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .dut_a(a_v[1]), .dut_b(b_v[1]),
        .dut_y(y_v[1]), .truth(truth_v[1]), .func_code(func_v[1]), .pass(pass_v[1]));

    gate_identifier #(.SETTLE_CYCLES(255)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .expect_code(exp_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .dut_a(a_v[2]), .dut_b(b_v[2]),
        .dut_y(y_v[2]), .truth(truth_v[2]), .func_code(func_v[2]), .pass(pass_v[2]));

    always_comb begin
        y_v = 3'b000;
        for (int k = 0; k < 3; k++) begin
            y_v[k] = lat_v[k] ? p2[k] : tbl_v[k][{a_v[k], b_v[k]}];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            p1[k] <= tbl_v[k][{a_v[k], b_v[k]}];
            p2[k] <= p1[k];
            if (done_v[k]) dcount[k] <= dcount[k] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int settle(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 255);
    endfunction

    function automatic logic [2:0] model_code(input logic [3:0] t);
        for (int c = 1; c < 8; c++) begin
            if (KNOWN[c] == t) return 3'(c);
        end
        return 3'd0;
    endfunction

    // One sweep on instance k. Starts from a negedge, returns on the negedge
    // after done is first seen (plus one more negedge unless hold is set).
    task automatic run_sweep(input int k, input logic [3:0] tbl, input bit lat,
                             input logic [2:0] exp, input bit chk, input int pulse_at,
                             input bit hold, input bit vec_chk);
        int n;
        int per;
        int d0;
        per = settle(k) + 1;
        tbl_v[k] = tbl;
        lat_v[k] = lat;
        exp_v[k] = exp;
        start_v[k] = 1'b1;
        d0 = dcount[k];
        @(posedge clk);          // edge 0 accepts start
        @(negedge clk);
        start_v[k] = 1'b0;
        exp_v[k] = ~exp;         // must have been captured already
        n = 0;
        check("busy_after_start", busy_v[k], 1);
        while (!done_v[k] && n < 4 * per + 20) begin
            if (vec_chk && (n % per == 0) && n < 4 * per)
                check($sformatf("vec_at_edge%0d", n), {a_v[k], b_v[k]}, n / per);
            if (vec_chk && n < 4 * per)
                check($sformatf("busy_edge%0d", n), busy_v[k], 1);
            @(negedge clk);
            n++;
            if (hold && n >= 3) start_v[k] = 1'b1;
            else start_v[k] = (n == pulse_at);
        end
        check($sformatf("done_edge_k%0d", k), n, 4 * per);
        check("busy_low_at_done", busy_v[k], 0);
        check("vec_holds_11", {a_v[k], b_v[k]}, 3);
        if (chk) begin
            check("truth", truth_v[k], tbl);
            check("func_code", func_v[k], model_code(tbl));
            check("pass", pass_v[k], model_code(tbl) == exp);
        end
        if (!hold) begin
            @(negedge clk);
            check("done_one_cycle", done_v[k], 0);
            check("done_pulse_count", dcount[k] - d0, 1);
        end
    endtask

    logic [3:0] dir_tbl [7] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b1001, 4'b0011, 4'b0000};
    logic [2:0] dir_code [7] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7, 3'd0};

    initial begin
        int d0;
        int m;
        logic [3:0] t;
        for (int k = 0; k < 3; k++) begin
            tbl_v[k] = 4'b0000;
            exp_v[k] = 3'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy_v[0], 0);
        check("rst_done", done_v[0], 0);
        check("rst_ab", {a_v[0], b_v[0]}, 0);
        check("rst_truth", truth_v[0], 0);
        check("rst_func", func_v[0], 0);
        check("rst_pass", pass_v[0], 0);
        rst = 1'b0;
        @(negedge clk);

        // NOR with vector timing checks
        run_sweep(0, 4'b0001, 1'b0, 3'd4, 1'b1, -1, 1'b0, 1'b1);
        check("nor_truth", truth_v[0], 4'b0001);
        check("nor_func", func_v[0], 4);
        check("nor_pass", pass_v[0], 1);

        // Other gates against expect_code = 1
        for (int i = 0; i < 7; i++) begin
            run_sweep(0, dir_tbl[i], 1'b0, 3'd1, 1'b1, -1, 1'b0, 1'b0);
            check($sformatf("dir_func%0d", i), func_v[0], dir_code[i]);
            check($sformatf("dir_pass%0d", i), pass_v[0], dir_code[i] == 3'd1);
        end

        // Slow gate: misclassified with 1 settle cycle, correct with 2
        run_sweep(0, 4'b0110, 1'b1, 3'd3, 1'b0, -1, 1'b0, 1'b0);
        check("lat1_misclass", func_v[0] == 3'd3, 0);
        check("lat1_nopass", pass_v[0], 0);
        run_sweep(1, 4'b0110, 1'b1, 3'd3, 1'b1, -1, 1'b0, 1'b0);
        lat_v = 3'b000;

        // Start mid-sweep ignored
        run_sweep(0, 4'b1000, 1'b0, 3'd1, 1'b1, 3, 1'b0, 1'b0);

        // Start held through done: back-to-back sweep accepted on the done cycle
        run_sweep(0, 4'b1110, 1'b0, 3'd2, 1'b1, -1, 1'b1, 1'b0);
        @(negedge clk);
        check("b2b_busy", busy_v[0], 1);
        check("b2b_done_low", done_v[0], 0);
        start_v[0] = 1'b0;
        m = 9;
        while (!done_v[0] && m < 40) begin
            @(negedge clk);
            m++;
        end
        check("b2b_done_edge", m, 17);
        check("b2b_truth", truth_v[0], 4'b1110);
        @(negedge clk);

        // Reset at cycle 5 of a sweep
        tbl_v[0] = 4'b0110;
        exp_v[0] = 3'd3;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        d0 = dcount[0];
        @(negedge clk);
        check("mid_rst_busy", busy_v[0], 0);
        check("mid_rst_ab", {a_v[0], b_v[0]}, 0);
        check("mid_rst_truth", truth_v[0], 0);
        check("mid_rst_func", func_v[0], 0);
        check("mid_rst_done", done_v[0], 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("mid_rst_no_done", dcount[0] - d0, 0);
        check("mid_rst_idle", busy_v[0], 0);
        run_sweep(0, 4'b0110, 1'b0, 3'd3, 1'b1, -1, 1'b0, 1'b0);

        // Randomized tables and expect codes on the short-settle instances
        for (int i = 0; i < 16; i++) begin
            t = $urandom_range(0, 1) ? KNOWN[$urandom_range(1, 7)] : 4'($urandom);
            run_sweep($urandom_range(0, 1), t, 1'b0, 3'($urandom), 1'b1, -1, 1'b0, 1'b0);
        end

        // Maximum settle time
        run_sweep(2, 4'b0110, 1'b0, 3'd3, 1'b1, -1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
